// File: rtl/set_bit_scanner.sv
// Purpose : streams every set bit of an accepted word, one beat per set bit, LSB- or MSB-first.
// Latency : first beat is valid the cycle after accept; one beat per cycle under ready_i = 1.
// Backpr. : while val_o & !ready_i all outputs and the residual hold; a new word is taken on the last handshake.
//
// Ports:
//   clk_i, arst_i            clock (rising edge), asynchronous active-high reset
//   data_i, msb_first_i      word to scan and its scan order, latched on accept
//   data_val_i/data_ready_o  input word handshake
//   onehot_o, index_o        one-hot mask and LSB-relative index of the current set bit
//   last_o, empty_o          final beat of the word / accepted word was all-zero
//   val_o/ready_i            output beat handshake
module set_bit_scanner #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] onehot_o,
  output logic [IDX_W-1:0]  index_o,
  output logic              last_o,
  output logic              empty_o,
  output logic              val_o,
  input  logic              ready_i
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] residual_q, residual_d;
  logic              msb_first_q, msb_first_d;
  logic              empty_q, empty_d;

  logic [DATA_W-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              at_most_one;
  logic              out_hs;
  logic              accept;

  // Pick from the residual only, so data_i never reaches an output.
  // The residual is zero in IDLE, so the pick is zero there as well.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    if (msb_first_q) begin
      // Ascending scan: the highest set bit is the last one to win.
      for (int i = 0; i < DATA_W; i++) begin
        if (residual_q[i]) begin
          pick_oh    = '0;
          pick_oh[i] = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Descending scan: the lowest set bit is the last one to win.
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (residual_q[i]) begin
          pick_oh    = '0;
          pick_oh[i] = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Zero or one bit left: covers both the final set bit and the empty word.
  assign at_most_one = ((residual_q & (residual_q - ONE)) == '0);

  assign val_o        = (state_q == SCAN);
  assign last_o       = val_o & at_most_one;
  assign empty_o      = val_o & empty_q;
  assign onehot_o     = pick_oh;
  assign index_o      = pick_idx;
  assign out_hs       = val_o & ready_i;
  // Reloading on the last handshake keeps words back-to-back without a bubble.
  assign data_ready_o = (state_q == IDLE) | (out_hs & last_o);
  assign accept       = data_val_i & data_ready_o;

  always_comb begin
    state_d     = state_q;
    residual_d  = residual_q;
    msb_first_d = msb_first_q;
    empty_d     = empty_q;
    if (out_hs) begin
      residual_d = residual_q & ~pick_oh;
      if (last_o) begin
        state_d = IDLE;
      end
    end
    // A same-cycle accept overrides the return to IDLE.
    if (accept) begin
      state_d     = SCAN;
      residual_d  = data_i;
      msb_first_d = msb_first_i;
      empty_d     = (data_i == '0);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      residual_q  <= '0;
      msb_first_q <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      residual_q  <= residual_d;
      msb_first_q <= msb_first_d;
      empty_q     <= empty_d;
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Purpose : scoreboard bench for set_bit_scanner with directed words and hand-written expected beats.
// Latency : stimulus drives 1 time unit after the rising edge; the monitor samples on the falling edge.
// Backpr. : ready_i is driven by the stimulus; the monitor pops only on beats that will handshake.
module tb_set_bit_scanner;

  typedef struct packed {
    logic [15:0] oh;
    logic [3:0]  idx;
    logic        last;
    logic        empty;
  } exp_t;

  logic        clk;
  logic        arst;
  logic [15:0] data_i;
  logic        msb_first_i;
  logic        data_val_i;
  logic        data_ready_o;
  logic [15:0] onehot_o;
  logic [3:0]  index_o;
  logic        last_o;
  logic        empty_o;
  logic        val_o;
  logic        ready_i;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  set_bit_scanner #(.DATA_W(16)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .data_i       (data_i),
    .msb_first_i  (msb_first_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .onehot_o     (onehot_o),
    .index_o      (index_o),
    .last_o       (last_o),
    .empty_o      (empty_o),
    .val_o        (val_o),
    .ready_i      (ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] oh, input logic [3:0] idx, input logic last, input logic empty);
    exp_t e;
    e.oh    = oh;
    e.idx   = idx;
    e.last  = last;
    e.empty = empty;
    sb_q.push_back(e);
  endtask

  // Monitor: a beat seen valid with ready high handshakes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!arst && val_o && ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", {28'd0, index_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("beat_onehot", {16'd0, onehot_o}, {16'd0, e.oh});
        check("beat_index",  {28'd0, index_o},  {28'd0, e.idx});
        check("beat_last",   {31'd0, last_o},   {31'd0, e.last});
        check("beat_empty",  {31'd0, empty_o},  {31'd0, e.empty});
      end
    end
  end

  // Presents a word, waits (bounded) for acceptance, returns 1 unit after the accepting edge.
  task automatic send_word(input logic [15:0] d, input logic m);
    int waited;
    data_i      = d;
    msb_first_i = m;
    data_val_i  = 1'b1;
    waited      = 0;
    @(negedge clk);
    while (!data_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    data_val_i  = 1'b0;
    // Scrambled inputs during SCAN must not matter.
    data_i      = 16'h5A5A;
    msb_first_i = ~m;
  endtask

  // Counts consecutive valid cycles from the current point until IDLE.
  task automatic drain(input string name, input int exp_beats);
    int cycles;
    cycles = 0;
    while (val_o && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check(name, cycles, exp_beats);
  endtask

  initial begin
    arst        = 1'b1;
    data_i      = 16'hFFFF;
    msb_first_i = 1'b0;
    data_val_i  = 1'b1;   // must be ignored while reset is high
    ready_i     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_val",    {31'd0, val_o},        32'd0);
    check("rst_onehot", {16'd0, onehot_o},     32'd0);
    check("rst_index",  {28'd0, index_o},      32'd0);
    check("rst_last",   {31'd0, last_o},       32'd0);
    check("rst_empty",  {31'd0, empty_o},      32'd0);
    check("rst_ready",  {31'd0, data_ready_o}, 32'd1);
    data_val_i = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_val", {31'd0, val_o}, 32'd0);

    // LSB-first 8421
    push_exp(16'h0001, 4'd0,  1'b0, 1'b0);
    push_exp(16'h0020, 4'd5,  1'b0, 1'b0);
    push_exp(16'h0400, 4'd10, 1'b0, 1'b0);
    push_exp(16'h8000, 4'd15, 1'b1, 1'b0);
    send_word(16'h8421, 1'b0);
    drain("lsb_8421_beats", 4);

    // MSB-first 8421
    push_exp(16'h8000, 4'd15, 1'b0, 1'b0);
    push_exp(16'h0400, 4'd10, 1'b0, 1'b0);
    push_exp(16'h0020, 4'd5,  1'b0, 1'b0);
    push_exp(16'h0001, 4'd0,  1'b1, 1'b0);
    send_word(16'h8421, 1'b1);
    drain("msb_8421_beats", 4);

    // Empty word
    push_exp(16'h0000, 4'd0, 1'b1, 1'b1);
    send_word(16'h0000, 1'b0);
    drain("empty_beats", 1);
    check("empty_idle_ready", {31'd0, data_ready_o}, 32'd1);

    // Backpressure on 0003
    ready_i = 1'b0;
    push_exp(16'h0001, 4'd0, 1'b0, 1'b0);
    push_exp(16'h0002, 4'd1, 1'b1, 1'b0);
    send_word(16'h0003, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("bp_val",    {31'd0, val_o},    32'd1);
      check("bp_onehot", {16'd0, onehot_o}, 32'h0001);
      check("bp_index",  {28'd0, index_o},  32'd0);
      check("bp_ready",  {31'd0, data_ready_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    drain("bp_beats", 2);

    // Back-to-back, data_val_i held high across the last handshake
    push_exp(16'h0001, 4'd0,  1'b1, 1'b0);
    push_exp(16'h8000, 4'd15, 1'b1, 1'b0);
    send_word(16'h0001, 1'b1);
    data_i      = 16'h8000;
    msb_first_i = 1'b1;
    data_val_i  = 1'b1;
    check("b2b_first_index", {28'd0, index_o},      32'd0);
    check("b2b_ready_on_last", {31'd0, data_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
    check("b2b_second_val",   {31'd0, val_o},   32'd1);
    check("b2b_second_index", {28'd0, index_o}, 32'd15);
    drain("b2b_tail_beats", 1);

    // FFFF with reset after the sixth beat
    for (int i = 0; i < 16; i++) push_exp(16'h0001 << i, 4'(i), (i == 15), 1'b0);
    send_word(16'hFFFF, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("ffff_idx_before_rst", {28'd0, index_o}, 32'd6);
    arst = 1'b1;
    #1;
    check("midrst_val",     {31'd0, val_o},  32'd0);
    check("midrst_consumed", sb_q.size(),    32'd10);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1;
    check("midrst_ready", {31'd0, data_ready_o}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("midrst_no_stale", {31'd0, val_o}, 32'd0);
    end

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_bit_scanner.md
# set_bit_scanner

Streaming successor to the single-shot priority encoder. Accepts one `DATA_W`-bit word per transaction and emits every set bit, one per beat, in priority order. The order is selectable per word: LSB-first or MSB-first. Each beat carries the bit's one-hot mask, its binary index and a last flag. The block sits between a request/flag source and any consumer that must service set bits one at a time, such as an arbiter grant sequencer or an interrupt dispatcher. Both sides use valid/ready handshakes.

## Interface
Parameters:
- `DATA_W`, default 16: input word width; legal range ≥ 2.
- `IDX_W`, default `$clog2(DATA_W)`: index width; derived, never overridden.

Ports:
- `clk_i`, input, 1: clock; all logic is on the rising edge.
- `arst_i`, input, 1: reset; asynchronous, active-high.
- `data_i`, input, `DATA_W`: word to scan.
- `msb_first_i`, input, 1: scan order. 0 = LSB-first, 1 = MSB-first. Sampled together with `data_i`.
- `data_val_i`, input, 1: input word valid.
- `data_ready_o`, output, 1: block can accept a word.
- `onehot_o`, output, `DATA_W`: one-hot mask of the current set bit.
- `index_o`, output, `IDX_W`: bit position of `onehot_o`, counted from the LSB in both orders.
- `last_o`, output, 1: current beat is the final beat of the word.
- `empty_o`, output, 1: accepted word was all-zero.
- `val_o`, output, 1: output beat valid.
- `ready_i`, input, 1: downstream accepts the beat.

## Operation
- Two states:
  - IDLE: no word held. `val_o` = 0, `data_ready_o` = 1.
  - SCAN: residual word held. `val_o` = 1.
- Accept: `data_val_i & data_ready_o` at a clock edge. On accept, the residual register loads `data_i`, the mode register loads `msb_first_i`, and the state becomes SCAN.
- Current pick, computed from the residual register only:
  - LSB-first: lowest set bit of the residual.
  - MSB-first: highest set bit of the residual.
- Output handshake: `val_o & ready_i` at an edge. The picked bit is cleared from the residual.
  - If `last_o` = 1, the state returns to IDLE.
  - Otherwise the state stays in SCAN.
- `last_o` = 1 when the residual has exactly one set bit, or when the residual is zero (empty word).
- Empty word: produces exactly one beat with `onehot_o` = 0, `index_o` = 0, `empty_o` = 1, `last_o` = 1.
- Beats per word: max(popcount, 1).
- `data_ready_o` = IDLE | (`val_o & last_o & ready_i`). A new word can be accepted in the same cycle as the previous word's last handshake. This is the only combinational input-to-output path.
- Mode and data are latched at accept. Changes on `msb_first_i` or `data_i` during SCAN have no effect.
- No combinational path from `data_i` to any output.

## Timing
- Reset (asynchronous assert, registers cleared immediately):
  - State IDLE, residual 0.
  - `val_o`, `onehot_o`, `index_o`, `last_o`, `empty_o` = 0; `data_ready_o` = 1.
  - `data_val_i` is ignored while `arst_i` is high.
- Latency: a word accepted at edge N gives `val_o` = 1 in the cycle after edge N, carrying the first pick.
- Throughput:
  - Under continuous `ready_i` = 1, one beat per cycle with no bubbles inside a word or between words.
  - A stream of words with popcount k_i occupies Σ max(k_i, 1) cycles.
- Backpressure: while `val_o & !ready_i`, all outputs hold stable and the residual is unchanged.
- Reset mid-scan: `val_o` drops to 0 asynchronously. The residual is discarded and no further beats from that word appear after release.
- Once `val_o` rises it stays high until the last handshake. The protocol never withdraws a beat.

## Test plan
- LSB-first, `data_i` = 16'h8421, `ready_i` = 1: four consecutive beats.
  - `index_o` = 0, 5, 10, 15.
  - `onehot_o` = 16'h0001, 16'h0020, 16'h0400, 16'h8000.
  - `last_o` = 1 only on the 4th beat; `empty_o` = 0 throughout.
- MSB-first, same word: `index_o` = 15, 10, 5, 0; `last_o` on `index_o` = 0.
- `data_i` = 16'h0000: exactly one beat with `onehot_o` = 0, `index_o` = 0, `empty_o` = 1, `last_o` = 1; then IDLE.
- Backpressure, `data_i` = 16'h0003, LSB-first, `ready_i` low for 3 cycles:
  - `onehot_o` = 16'h0001, `index_o` = 0 held stable for all 3 cycles.
  - After `ready_i` rises: beats 0 then 1, `last_o` on the second.
- Back-to-back with `data_val_i` held high: 16'h0001 then 16'h8000 MSB-first.
  - The second word is accepted on the first word's last handshake.
  - Beats `index_o` = 0 then 15 on adjacent cycles.
- `data_i` = 16'hFFFF LSB-first: 16 beats with `index_o` = 0..15.
  - Assert `arst_i` after beat 5: `val_o` goes to 0 immediately.
  - After release: `data_ready_o` = 1 and no stale beats appear.
